// File: rtl/bp_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared branch-type codes, counter encodings and the BTB entry
//               layout used by branch_predictor and its sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  // Execute-stage branch type codes (2'b11 is treated as a non-branch)
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;

  // 2-bit direction counter states; bit 1 is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is kept at its widest possible size (IDX_W >= 1) and zero-extended,
  // so one struct serves every ENTRIES setting.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// ============================================================================
// Module      : bp_sat_ctr
// Description : Combinational 2-bit saturating counter next-state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  // Step toward the observed outcome, holding at either end of the range
  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit direction counters. Combinational
//               fetch lookup, execute-stage training and mispredict redirect.
//               Optional statistics counters: BRANCH_PREDICTOR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_f_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic [31:0] o_pred_next_pc,
  input  logic        i_e_valid,
  input  logic [1:0]  i_e_br_type,
  input  logic [31:0] i_e_pc,
  input  logic        i_e_take_branch,
  input  logic [31:0] i_e_target,
  input  logic        i_e_pred_taken,
  input  logic [31:0] i_e_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispredicts
);

  btb_entry_t       r_tab [ENTRIES];

  logic [IDX_W-1:0] w_f_idx, w_e_idx;
  logic [29:0]      w_f_tag, w_e_tag;
  btb_entry_t       w_f_ent, w_e_ent;
  logic             w_f_hit, w_e_hit;
  logic [31:0]      w_f_seq, w_e_seq;
  logic             w_rv, w_taken, w_stale;
  logic [1:0]       w_ctr_nxt;
  logic             w_unused_pc_lsbs;

  // ---------------- fetch-side lookup (reads pre-update contents) ---------
  assign w_f_idx        = i_f_pc[IDX_W+1:2];
  assign w_f_tag        = 30'(i_f_pc >> (IDX_W + 2));
  assign w_f_ent        = r_tab[w_f_idx];
  assign w_f_hit        = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
  assign w_f_seq        = i_f_pc + 32'd4;
  assign o_pred_taken   = w_f_hit && w_f_ent.ctr[1];
  assign o_pred_target  = w_f_hit ? w_f_ent.target : w_f_seq;
  assign o_pred_next_pc = o_pred_taken ? o_pred_target : w_f_seq;

  // ---------------- execute-side resolve ----------------------------------
  assign w_e_idx = i_e_pc[IDX_W+1:2];
  assign w_e_tag = 30'(i_e_pc >> (IDX_W + 2));
  assign w_e_ent = r_tab[w_e_idx];
  assign w_e_hit = w_e_ent.valid && (w_e_ent.tag == w_e_tag);
  assign w_e_seq = i_e_pc + 32'd4;

  assign w_rv    = i_e_valid && ((i_e_br_type == BR_COND) || (i_e_br_type == BR_JUMP));
  // Jumps are unconditionally taken regardless of the condition logic
  assign w_taken = i_e_take_branch || (i_e_br_type == BR_JUMP);
  // A non-branch that carried a taken prediction came from a stale BTB hit
  assign w_stale = i_e_valid && !w_rv && i_e_pred_taken;

  assign o_mispredict  = rst_n &&
                         ((w_rv && ((w_taken != i_e_pred_taken) ||
                                    (w_taken && (i_e_pred_target != i_e_target)))) ||
                          w_stale);
  assign o_redirect_pc = (rst_n && w_rv && w_taken) ? i_e_target : w_e_seq;

  // PCs are word aligned; the low two bits carry no information
  assign w_unused_pc_lsbs = ^{i_f_pc[1:0], i_e_pc[1:0]};

  bp_sat_ctr u_sat_ctr (
    .i_ctr   (w_e_ent.ctr),
    .i_taken (w_taken),
    .o_ctr   (w_ctr_nxt)
  );

  // Table training: counter/target update on hit, allocate on taken miss,
  // invalidate on stale hit; reset drops any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (w_rv) begin
      if (w_e_hit) begin
        r_tab[w_e_idx].ctr <= w_ctr_nxt;
        if (w_taken) r_tab[w_e_idx].target <= i_e_target;
      end else if (w_taken) begin
        r_tab[w_e_idx] <= '{valid: 1'b1, tag: w_e_tag, target: i_e_target, ctr: CTR_WT};
      end
    end else if (w_stale && w_e_hit) begin
      r_tab[w_e_idx].valid <= 1'b0;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Free-running event counters, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_rv)         r_stat_br <= r_stat_br + 32'd1;
      if (o_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign o_stat_branches    = r_stat_br;
  assign o_stat_mispredicts = r_stat_mp;
`else
  assign o_stat_branches    = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a table-level behavioural model.
//               Honours BRANCH_PREDICTOR_STATS_EN for the statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  localparam int          NENT   = 16;
  localparam logic [31:0] NENT32 = 32'd16;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_f_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target, o_pred_next_pc;
  logic        i_e_valid;
  logic [1:0]  i_e_br_type;
  logic [31:0] i_e_pc;
  logic        i_e_take_branch;
  logic [31:0] i_e_target;
  logic        i_e_pred_taken;
  logic [31:0] i_e_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc, o_stat_branches, o_stat_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // model state
  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  logic [31:0] m_cnt_br, m_cnt_mp;

  branch_predictor #(.ENTRIES(NENT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_f_pc             (i_f_pc),
    .o_pred_taken       (o_pred_taken),
    .o_pred_target      (o_pred_target),
    .o_pred_next_pc     (o_pred_next_pc),
    .i_e_valid          (i_e_valid),
    .i_e_br_type        (i_e_br_type),
    .i_e_pc             (i_e_pc),
    .i_e_take_branch    (i_e_take_branch),
    .i_e_target         (i_e_target),
    .i_e_pred_taken     (i_e_pred_taken),
    .i_e_pred_target    (i_e_pred_target),
    .o_mispredict       (o_mispredict),
    .o_redirect_pc      (o_redirect_pc),
    .o_stat_branches    (o_stat_branches),
    .o_stat_mispredicts (o_stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model helpers ----------------
  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % NENT32);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return (pc >> 2) / NENT32;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_rv();
    return i_e_valid && (i_e_br_type == 2'b01 || i_e_br_type == 2'b10);
  endfunction

  function automatic bit exp_mp();
    if (!rst_n) return 1'b0;
    if (m_rv())
      return (i_e_take_branch != i_e_pred_taken) ||
             (i_e_take_branch && (i_e_pred_target != i_e_target));
    return i_e_valid && i_e_pred_taken;
  endfunction

  function automatic logic [31:0] exp_redirect();
    if (rst_n && m_rv() && i_e_take_branch) return i_e_target;
    return i_e_pc + 32'd4;
  endfunction

  // model table and statistics, trained from the execute report each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= '0;
        m_tgt[i]   <= '0;
        m_ctr[i]   <= 1;
      end
      m_cnt_br <= '0;
      m_cnt_mp <= '0;
    end else begin
      if (m_rv()) begin
        m_cnt_br <= m_cnt_br + 32'd1;
        if (m_hit(i_e_pc)) begin
          if (i_e_take_branch) begin
            m_ctr[m_idx(i_e_pc)] <= (m_ctr[m_idx(i_e_pc)] < 3) ? m_ctr[m_idx(i_e_pc)] + 1 : 3;
            m_tgt[m_idx(i_e_pc)] <= i_e_target;
          end else begin
            m_ctr[m_idx(i_e_pc)] <= (m_ctr[m_idx(i_e_pc)] > 0) ? m_ctr[m_idx(i_e_pc)] - 1 : 0;
          end
        end else if (i_e_take_branch) begin
          m_valid[m_idx(i_e_pc)] <= 1'b1;
          m_tag[m_idx(i_e_pc)]   <= m_tagof(i_e_pc);
          m_tgt[m_idx(i_e_pc)]   <= i_e_target;
          m_ctr[m_idx(i_e_pc)]   <= 2;
        end
      end else if (i_e_valid && i_e_pred_taken && m_hit(i_e_pc)) begin
        m_valid[m_idx(i_e_pc)] <= 1'b0;
      end
      if (exp_mp()) m_cnt_mp <= m_cnt_mp + 32'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cmp_pred_taken",  {31'd0, o_pred_taken}, {31'd0, m_ptaken(i_f_pc)});
        chk("cmp_pred_target", o_pred_target, m_ptgt(i_f_pc));
        chk("cmp_pred_next",   o_pred_next_pc,
            m_ptaken(i_f_pc) ? m_ptgt(i_f_pc) : i_f_pc + 32'd4);
        chk("cmp_mispredict",  {31'd0, o_mispredict}, {31'd0, exp_mp()});
        chk("cmp_redirect",    o_redirect_pc, exp_redirect());
`ifdef BRANCH_PREDICTOR_STATS_EN
        chk("cmp_stat_br", o_stat_branches,    m_cnt_br);
        chk("cmp_stat_mp", o_stat_mispredicts, m_cnt_mp);
`else
        chk("cmp_stat_br", o_stat_branches,    32'd0);
        chk("cmp_stat_mp", o_stat_mispredicts, 32'd0);
`endif
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic exe(input logic v, input logic [1:0] t, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    i_e_valid       = v;
    i_e_br_type     = t;
    i_e_pc          = pc;
    i_e_take_branch = tk;
    i_e_target      = tg;
    i_e_pred_taken  = pt;
    i_e_pred_target = ptg;
  endtask

  task automatic idle();
    exe(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h1000 + ($urandom_range(0, 3) * 32'd64) + ($urandom_range(0, 15) * 32'd4);
  endfunction

  initial begin
    fork
      compare_loop();
    join_none

    // ---- reset behaviour ----
    rst_n  = 1'b0;
    i_f_pc = 32'h100;
    idle();
    #12;
    cmp_en = 1'b1;
    chk("rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    chk("rst_pred_next",  o_pred_next_pc, 32'h104);
    chk("rst_pred_tgt",   o_pred_target,  32'h104);
    exe(1'b1, 2'b00, 32'h300, 1'b0, 32'h0, 1'b1, 32'h999);
    #1;
    chk("rst_mp_forced0", {31'd0, o_mispredict}, 32'd0);
    chk("rst_redirect",   o_redirect_pc, 32'h304);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- first allocation ----
    exe(1'b1, 2'b01, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    #1;
    chk("alloc_mp",       {31'd0, o_mispredict}, 32'd1);
    chk("alloc_redirect", o_redirect_pc, 32'h200);
    step(); idle(); #1;
    chk("alloc_pred_taken", {31'd0, o_pred_taken}, 32'd1);
    chk("alloc_pred_next",  o_pred_next_pc, 32'h200);

    // ---- counter saturation and decay ----
    repeat (3) begin
      exe(1'b1, 2'b01, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      #1;
      chk("train_taken_mp", {31'd0, o_mispredict}, 32'd0);
      step();
    end
    exe(1'b1, 2'b01, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    chk("nt1_mp",       {31'd0, o_mispredict}, 32'd1);
    chk("nt1_redirect", o_redirect_pc, 32'h104);
    step(); idle(); #1;
    chk("nt1_still_taken", {31'd0, o_pred_taken}, 32'd1);
    exe(1'b1, 2'b01, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    step(); idle(); #1;
    chk("nt2_pred_nt",   {31'd0, o_pred_taken}, 32'd0);
    chk("nt2_pred_next", o_pred_next_pc, 32'h104);

    // ---- wrong target ----
    exe(1'b1, 2'b01, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    chk("tgt_mp",       {31'd0, o_mispredict}, 32'd1);
    chk("tgt_redirect", o_redirect_pc, 32'h300);
    step(); idle(); #1;
    chk("tgt_updated", o_pred_next_pc, 32'h300);

    // ---- aliasing eviction ----
    exe(1'b1, 2'b01, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
    step(); idle(); #1;
    chk("evict_old_miss", {31'd0, o_pred_taken}, 32'd0);
    chk("evict_old_next", o_pred_next_pc, 32'h104);
    i_f_pc = 32'h140;
    #1;
    chk("evict_new_next", o_pred_next_pc, 32'h500);

    // ---- jump allocation, then stale hit on a non-branch ----
    exe(1'b1, 2'b10, 32'h180, 1'b1, 32'h600, 1'b0, 32'h184);
    step(); idle();
    i_f_pc = 32'h180;
    #1;
    chk("jump_pred_next", o_pred_next_pc, 32'h600);
    exe(1'b1, 2'b00, 32'h180, 1'b0, 32'h0, 1'b1, 32'h600);
    #1;
    chk("stale_mp",       {31'd0, o_mispredict}, 32'd1);
    chk("stale_redirect", o_redirect_pc, 32'h184);
    step(); idle(); #1;
    chk("stale_invalidated", {31'd0, o_pred_taken}, 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("dir_stat_br", o_stat_branches,    32'd9);
    chk("dir_stat_mp", o_stat_mispredicts, 32'd7);
`else
    chk("dir_stat_br", o_stat_branches,    32'd0);
    chk("dir_stat_mp", o_stat_mispredicts, 32'd0);
`endif

    // ---- randomized traffic ----
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] epc;
      logic [1:0]  ty;
      epc = rnd_pc();
      ty  = 2'($urandom_range(0, 3));
      i_e_valid       = ($urandom_range(0, 9) < 8);
      i_e_br_type     = ty;
      i_e_pc          = epc;
      i_e_take_branch = (ty == 2'b10) ? 1'b1 : 1'($urandom_range(0, 1));
      i_e_target      = 32'h8000 + $urandom_range(0, 3) * 32'd4;
      if ($urandom_range(0, 3) != 0) begin
        i_e_pred_taken  = m_ptaken(epc);
        i_e_pred_target = m_ptgt(epc);
      end else begin
        i_e_pred_taken  = 1'($urandom_range(0, 1));
        i_e_pred_target = 32'h8000 + $urandom_range(0, 3) * 32'd4;
      end
      i_f_pc = ($urandom_range(0, 1) == 1) ? epc : rnd_pc();
      step();
    end

    // ---- asynchronous reset with a write pending ----
    exe(1'b1, 2'b01, 32'h2000, 1'b1, 32'h9000, 1'b0, 32'h2004);
    i_f_pc = 32'h2000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stat_br", o_stat_branches,    32'd0);
    chk("mid_rst_stat_mp", o_stat_mispredicts, 32'd0);
    chk("mid_rst_mp",      {31'd0, o_mispredict}, 32'd0);
    chk("mid_rst_redirect", o_redirect_pc, 32'h2004);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle();
    step();
    #1;
    chk("mid_rst_write_dropped", {31'd0, o_pred_taken}, 32'd0);
    for (int k = 0; k < NENT; k++) begin
      i_f_pc = 32'h1000 + k * 4;
      #1;
      chk("post_rst_miss", o_pred_target, 32'h1004 + k * 4);
    end
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
